load_store_unit: RTL

//  Memory-execution stage directly downstream of the address buffer queue. Pops one

---
 rtl/load_store_unit_if.sv | 42 ++++
 rtl/load_store_unit.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/load_store_unit_if.sv
// Signal bundle between the load/store unit and its neighbours: the address
// buffer, the ROB head, the data cache port and the common data bus.
interface load_store_unit_if #(
  parameter int TAG_W = 4
) ();
  logic             flush;
  logic             vld_i;
  logic             rdy_i;
  logic             ab_is_store;
  logic [2:0]       ab_funct3;
  logic [31:0]      ab_addr;
  logic [31:0]      ab_wdata;
  logic [TAG_W-1:0] ab_tag;
  logic [TAG_W-1:0] rob_head_tag;
  logic             rob_head_store;
  logic             store_done;
  logic             dmem_read;
  logic             dmem_write;
  logic [31:0]      dmem_address;
  logic [31:0]      dmem_wdata;
  logic [3:0]       dmem_mbe;
  logic [31:0]      dmem_rdata;
  logic             dmem_resp;
  logic             cdb_vld;
  logic             cdb_rdy;
  logic [TAG_W-1:0] cdb_tag;
  logic [31:0]      cdb_data;

  modport slave (
    input  flush, vld_i, ab_is_store, ab_funct3, ab_addr, ab_wdata, ab_tag,
           rob_head_tag, rob_head_store, dmem_rdata, dmem_resp, cdb_rdy,
    output rdy_i, store_done, dmem_read, dmem_write, dmem_address, dmem_wdata,
           dmem_mbe, cdb_vld, cdb_tag, cdb_data
  );

  modport master (
    output flush, vld_i, ab_is_store, ab_funct3, ab_addr, ab_wdata, ab_tag,
           rob_head_tag, rob_head_store, dmem_rdata, dmem_resp, cdb_rdy,
    input  rdy_i, store_done, dmem_read, dmem_write, dmem_address, dmem_wdata,
           dmem_mbe, cdb_vld, cdb_tag, cdb_data
  );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit: pops one resolved memory op at a time, holds stores until
// the ROB head commits them, issues a single cache access, and broadcasts
// extended load results on the CDB.
module load_store_unit #(
  parameter int TAG_W = 4
) (
  input logic              clk,
  input logic              rst,
  load_store_unit_if.slave bus
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_COMMIT,
    ST_MEM,
    ST_BCAST,
    ST_DRAIN
  } state_t;

  state_t           r_state;
  state_t           w_nextState;
  logic             r_isStore;
  logic [2:0]       r_funct3;
  logic [31:0]      r_addr;
  logic [31:0]      r_wdata;
  logic [TAG_W-1:0] r_tag;
  logic [31:0]      r_loadData;
  logic             r_storeDone;

  logic             w_pop;
  logic             w_req;
  logic             w_isByte;
  logic             w_isHalf;
  logic             w_unsigned;
  logic [1:0]       w_off;
  logic [3:0]       w_mbe;
  logic [31:0]      w_wdata;
  logic [31:0]      w_loadExt;
  logic [7:0]       w_byte;
  logic [15:0]      w_half;

  assign w_pop      = bus.vld_i && bus.rdy_i;
  assign w_req      = bus.dmem_read || bus.dmem_write;
  assign w_off      = r_addr[1:0];
  // Store encodings with funct3[2] set are not real stores and fall back to word
  assign w_isByte   = (r_funct3[1:0] == 2'b00) && !(r_isStore && r_funct3[2]);
  assign w_isHalf   = (r_funct3[1:0] == 2'b01) && !(r_isStore && r_funct3[2]);
  assign w_unsigned = r_funct3[2];

  assign bus.dmem_address = {r_addr[31:2], 2'b00};
  assign bus.dmem_wdata   = w_wdata;
  assign bus.dmem_mbe     = w_req ? w_mbe : 4'b0000;
  assign bus.store_done   = r_storeDone;
  assign bus.cdb_tag      = r_tag;
  assign bus.cdb_data     = r_loadData;

  // Byte-lane steering for stores and lane extraction/extension for loads
  always_comb begin
    case (w_off)
      2'd0:    w_byte = bus.dmem_rdata[7:0];
      2'd1:    w_byte = bus.dmem_rdata[15:8];
      2'd2:    w_byte = bus.dmem_rdata[23:16];
      default: w_byte = bus.dmem_rdata[31:24];
    endcase
    w_half = w_off[1] ? bus.dmem_rdata[31:16] : bus.dmem_rdata[15:0];
    if (w_isByte) begin
      w_mbe     = 4'b0001 << w_off;
      w_wdata   = {4{r_wdata[7:0]}};
      w_loadExt = w_unsigned ? {24'd0, w_byte} : {{24{w_byte[7]}}, w_byte};
    end else if (w_isHalf) begin
      w_mbe     = w_off[1] ? 4'b1100 : 4'b0011;
      w_wdata   = {2{r_wdata[15:0]}};
      w_loadExt = w_unsigned ? {16'd0, w_half} : {{16{w_half[15]}}, w_half};
    end else begin
      w_mbe     = 4'b1111;
      w_wdata   = r_wdata;
      w_loadExt = bus.dmem_rdata;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_nextState;
  end

  // Next-state logic; a load flushed mid-access must still drain its response
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      ST_IDLE:
        if (w_pop) w_nextState = bus.ab_is_store ? ST_WAIT_COMMIT : ST_MEM;
      ST_WAIT_COMMIT:
        if (bus.flush) w_nextState = ST_IDLE;
        else if (bus.rob_head_store && (bus.rob_head_tag == r_tag)) w_nextState = ST_MEM;
      ST_MEM:
        if (r_isStore) begin
          if (bus.dmem_resp) w_nextState = ST_IDLE;
        end else if (bus.dmem_resp) begin
          w_nextState = bus.flush ? ST_IDLE : ST_BCAST;
        end else if (bus.flush) begin
          w_nextState = ST_DRAIN;
        end
      ST_BCAST:
        if (bus.flush || bus.cdb_rdy) w_nextState = ST_IDLE;
      ST_DRAIN:
        if (bus.dmem_resp) w_nextState = ST_IDLE;
      default:
        w_nextState = ST_IDLE;
    endcase
  end

  // Handshake and request outputs decoded from the current state
  always_comb begin
    bus.rdy_i      = 1'b0;
    bus.dmem_read  = 1'b0;
    bus.dmem_write = 1'b0;
    bus.cdb_vld    = 1'b0;
    case (r_state)
      ST_IDLE:  bus.rdy_i = !bus.flush;
      ST_MEM: begin
        bus.dmem_read  = !r_isStore;
        bus.dmem_write = r_isStore;
      end
      ST_BCAST: bus.cdb_vld = !bus.flush;
      ST_DRAIN: bus.dmem_read = 1'b1;
      default:  ;
    endcase
  end

  // Operation capture on pop, load result capture and the store-done pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      r_isStore   <= 1'b0;
      r_funct3    <= 3'd0;
      r_addr      <= 32'd0;
      r_wdata     <= 32'd0;
      r_tag       <= '0;
      r_loadData  <= 32'd0;
      r_storeDone <= 1'b0;
    end else begin
      r_storeDone <= (r_state == ST_MEM) && r_isStore && bus.dmem_resp;
      if (w_pop) begin
        r_isStore <= bus.ab_is_store;
        r_funct3  <= bus.ab_funct3;
        r_addr    <= bus.ab_addr;
        r_wdata   <= bus.ab_wdata;
        r_tag     <= bus.ab_tag;
      end
      if ((r_state == ST_MEM) && !r_isStore && bus.dmem_resp)
        r_loadData <= w_loadExt;
    end
  end

endmodule
